// File: rtl/riscv_dbg_pkg.sv
// Shared run-control types for the RV32I debug/run sequencer.
package riscv_dbg_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        STEP   = 2'd2
    } run_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE   = 3'd0,
        CAUSE_REQ    = 3'd1,
        CAUSE_BP     = 3'd2,
        CAUSE_EBREAK = 3'd3,
        CAUSE_STEP   = 3'd4
    } halt_cause_e;

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

endpackage

// File: rtl/bp_match.sv
// Address breakpoint slots: registered write port, combinational any-match vs PC.
module bp_match
    import riscv_dbg_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NUM_BP = 2,
    parameter int unsigned IDXW   = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_wr_en,
    input  logic [IDXW-1:0] i_wr_idx,
    input  logic [XLEN-1:0] i_wr_addr,
    input  logic            i_wr_valid,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_match
);

    logic [XLEN-1:0] r_addr  [NUM_BP];
    logic            r_valid [NUM_BP];

    // Slot writes; an index with no matching slot simply writes nothing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NUM_BP; i++) begin
                r_addr[i]  <= '0;
                r_valid[i] <= 1'b0;
            end
        end else if (i_wr_en) begin
            for (int unsigned i = 0; i < NUM_BP; i++) begin
                if (i_wr_idx == IDXW'(i)) begin
                    r_addr[i]  <= i_wr_addr;
                    r_valid[i] <= i_wr_valid;
                end
            end
        end
    end

    // Any enabled slot whose address equals the current PC.
    always_comb begin
        o_match = 1'b0;
        for (int unsigned i = 0; i < NUM_BP; i++) begin
            if (r_valid[i] && (r_addr[i] == i_pc)) begin
                o_match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_run_ctrl.sv
// Run-control sequencer for the single-cycle RV32I core: halt/resume/step,
// breakpoints, EBREAK halting and cycle/instret counters.
module core_run_ctrl
    import riscv_dbg_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NUM_BP       = 2,
    parameter bit          START_HALTED = 1'b0,
    parameter int unsigned IDXW         = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_instr,
    input  logic            i_halt_req,
    input  logic            i_resume_req,
    input  logic            i_step_req,
    input  logic            i_bp_wr_en,
    input  logic [IDXW-1:0] i_bp_wr_idx,
    input  logic [XLEN-1:0] i_bp_wr_addr,
    input  logic            i_bp_wr_valid,
    output logic            o_core_en,
    output logic            o_halted,
    output logic [2:0]      o_halt_cause,
    output logic [XLEN-1:0] o_cycle_cnt,
    output logic [XLEN-1:0] o_instret_cnt
);

    localparam run_state_e RESET_STATE = START_HALTED ? HALTED : RUN;

    run_state_e      r_state;
    run_state_e      w_state_nxt;
    halt_cause_e     r_cause;
    halt_cause_e     w_cause_nxt;
    logic            r_mask;
    logic            w_mask_nxt;
    logic            r_halted;
    logic            w_core_en;
    logic            w_bp_hit;
    logic            w_hit;
    logic [XLEN-1:0] r_cycle;
    logic [XLEN-1:0] r_instret;

    bp_match #(
        .XLEN   (XLEN),
        .NUM_BP (NUM_BP),
        .IDXW   (IDXW)
    ) u_bp_match (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_wr_en    (i_bp_wr_en),
        .i_wr_idx   (i_bp_wr_idx),
        .i_wr_addr  (i_bp_wr_addr),
        .i_wr_valid (i_bp_wr_valid),
        .i_pc       (i_pc),
        .o_match    (w_bp_hit)
    );

    // The mask suppresses the hit for the first RUN cycle after a resume so
    // the instruction that caused the halt executes once.
    assign w_hit = !r_mask && (w_bp_hit || (i_instr == EBREAK_INSN));

    // State, cause, mask and halted flag registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= RESET_STATE;
            r_cause  <= CAUSE_NONE;
            r_mask   <= 1'b0;
            r_halted <= START_HALTED;
        end else begin
            r_state  <= w_state_nxt;
            r_cause  <= w_cause_nxt;
            r_mask   <= w_mask_nxt;
            r_halted <= (w_state_nxt == HALTED);
        end
    end

    // Next-state, halt cause and core enable decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        w_mask_nxt  = r_mask;
        w_core_en   = 1'b0;
        unique case (r_state)
            RUN: begin
                w_mask_nxt = 1'b0;
                if (w_hit) begin
                    w_state_nxt = HALTED;
                    w_cause_nxt = w_bp_hit ? CAUSE_BP : CAUSE_EBREAK;
                end else begin
                    w_core_en = 1'b1;
                    if (i_halt_req) begin
                        w_state_nxt = HALTED;
                        w_cause_nxt = CAUSE_REQ;
                    end
                end
            end
            HALTED: begin
                if (i_resume_req && !i_halt_req) begin
                    w_state_nxt = RUN;
                    w_mask_nxt  = 1'b1;
                end else if (i_step_req) begin
                    w_state_nxt = STEP;
                end
            end
            STEP: begin
                w_core_en   = 1'b1;
                w_state_nxt = HALTED;
                w_cause_nxt = CAUSE_STEP;
            end
            default: begin
                w_state_nxt = HALTED;
            end
        endcase
    end

    // Free-running cycle counter and retired-instruction counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            r_cycle   <= r_cycle + XLEN'(1);
            r_instret <= r_instret + XLEN'(w_core_en);
        end
    end

    assign o_core_en     = w_core_en;
    assign o_halted      = r_halted;
    assign o_halt_cause  = r_cause;
    assign o_cycle_cnt   = r_cycle;
    assign o_instret_cnt = r_instret;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl: directed plan steps followed by a
// randomized phase, all checked against a behavioural model of the run rules.
module tb_core_run_ctrl;

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    int checks   = 0;
    int failures = 0;

    // Main DUT (XLEN=32, three slots so an out-of-range index exists)
    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        halt_req, resume_req, step_req;
    logic        bp_wr_en;
    logic [1:0]  bp_wr_idx;
    logic [31:0] bp_wr_addr;
    logic        bp_wr_valid;
    logic        core_en, halted;
    logic [2:0]  halt_cause;
    logic [31:0] cycle_cnt, instret_cnt;

    // Narrow DUT used to observe counter wrap in a few hundred cycles
    logic        rst2_n;
    logic [7:0]  pc2;
    logic [31:0] instr2;
    logic        zero1;
    logic [0:0]  idx2;
    logic [7:0]  addr2;
    logic        core_en2, halted2;
    logic [2:0]  cause2;
    logic [7:0]  cyc2, ret2;

    assign instr = (pc == 32'h40 || pc == 32'h6C) ? EBREAK : NOP;

    core_run_ctrl #(.XLEN(32), .NUM_BP(3), .START_HALTED(1'b0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pc(pc), .i_instr(instr),
        .i_halt_req(halt_req), .i_resume_req(resume_req), .i_step_req(step_req),
        .i_bp_wr_en(bp_wr_en), .i_bp_wr_idx(bp_wr_idx), .i_bp_wr_addr(bp_wr_addr),
        .i_bp_wr_valid(bp_wr_valid), .o_core_en(core_en), .o_halted(halted),
        .o_halt_cause(halt_cause), .o_cycle_cnt(cycle_cnt), .o_instret_cnt(instret_cnt)
    );

    core_run_ctrl #(.XLEN(8), .NUM_BP(1), .START_HALTED(1'b1)) dut_w (
        .i_clk(clk), .i_rst_n(rst2_n), .i_pc(pc2), .i_instr(instr2),
        .i_halt_req(zero1), .i_resume_req(zero1), .i_step_req(zero1),
        .i_bp_wr_en(zero1), .i_bp_wr_idx(idx2), .i_bp_wr_addr(addr2),
        .i_bp_wr_valid(zero1), .o_core_en(core_en2), .o_halted(halted2),
        .o_halt_cause(cause2), .o_cycle_cnt(cyc2), .o_instret_cnt(ret2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: halted / stepping / skip-once flags plus counters.
    bit          m_halted, m_step, m_skip, m_en;
    logic [2:0]  m_cause;
    logic [31:0] m_cyc, m_ret;
    logic [31:0] m_bpa [3];
    bit          m_bpv [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_halted = 1'b0;
        m_step   = 1'b0;
        m_skip   = 1'b0;
        m_cause  = 3'd0;
        m_cyc    = '0;
        m_ret    = '0;
        for (int i = 0; i < 3; i++) begin
            m_bpa[i] = '0;
            m_bpv[i] = 1'b0;
        end
    endtask

    function automatic bit bp_any(input logic [31:0] a);
        bit r = 1'b0;
        for (int i = 0; i < 3; i++) if (m_bpv[i] && m_bpa[i] == a) r = 1'b1;
        return r;
    endfunction

    task automatic clear_inputs();
        halt_req = 0; resume_req = 0; step_req = 0;
        bp_wr_en = 0; bp_wr_idx = '0; bp_wr_addr = '0; bp_wr_valid = 0;
    endtask

    // One clock: check core_en before the edge, advance model and PC, check outputs.
    task automatic tick();
        bit anyb, hit;
        #1;
        anyb = bp_any(pc);
        hit  = !m_skip && (anyb || instr == EBREAK);
        if (m_step)        m_en = 1'b1;
        else if (m_halted) m_en = 1'b0;
        else               m_en = !hit;
        chk("core_en", {31'd0, core_en}, {31'd0, m_en});
        @(posedge clk);
        #1;
        if (m_step) begin
            m_step = 1'b0; m_halted = 1'b1; m_cause = 3'd4;
        end else if (m_halted) begin
            if (resume_req && !halt_req) begin
                m_halted = 1'b0; m_skip = 1'b1;
            end else if (step_req) begin
                m_halted = 1'b0; m_step = 1'b1;
            end
        end else begin
            if (hit) begin
                m_halted = 1'b1; m_cause = anyb ? 3'd2 : 3'd3;
            end else if (halt_req) begin
                m_halted = 1'b1; m_cause = 3'd1;
            end
            m_skip = 1'b0;
        end
        if (bp_wr_en && bp_wr_idx < 2'd3) begin
            m_bpa[bp_wr_idx] = bp_wr_addr;
            m_bpv[bp_wr_idx] = bp_wr_valid;
        end
        m_cyc = m_cyc + 1;
        m_ret = m_ret + {31'd0, m_en};
        if (m_en) pc = (pc + 32'd4) & 32'h7F;
        chk("halted", {31'd0, halted}, {31'd0, m_halted});
        chk("halt_cause", {29'd0, halt_cause}, {29'd0, m_cause});
        chk("cycle_cnt", cycle_cnt, m_cyc);
        chk("instret_cnt", instret_cnt, m_ret);
    endtask

    initial begin
        logic [31:0] base;
        clear_inputs();
        rst_n = 1'b0; rst2_n = 1'b0; pc = '0;
        pc2 = '0; instr2 = NOP; zero1 = 1'b0; idx2 = '0; addr2 = '0;
        m_reset();
        #1;
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_cause", {29'd0, halt_cause}, 32'd0);
        chk("rst_cycle", cycle_cnt, 32'd0);
        chk("rst_core_en", {31'd0, core_en}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Free run for 10 clocks
        repeat (10) tick();
        chk("run10_cycle", cycle_cnt, 32'd10);
        chk("run10_instret", instret_cnt, 32'd10);

        // Breakpoint at 0x20, halt, resume executes it once
        bp_wr_en = 1; bp_wr_idx = 2'd0; bp_wr_addr = 32'h20; bp_wr_valid = 1;
        tick();
        clear_inputs();
        pc = 32'h18;
        repeat (3) tick();
        chk("bp_halted", {31'd0, halted}, 32'd1);
        chk("bp_cause", {29'd0, halt_cause}, 32'd2);
        chk("bp_instret", instret_cnt, 32'd13);
        chk("bp_pc", pc, 32'h20);
        tick();
        resume_req = 1; tick(); resume_req = 0;
        tick();
        chk("bp_resume_pc", pc, 32'h24);
        tick();
        chk("bp_no_rehalt", {31'd0, halted}, 32'd0);

        // EBREAK at 0x40
        repeat (7) tick();
        chk("ebreak_cause", {29'd0, halt_cause}, 32'd3);
        chk("ebreak_instret", instret_cnt, 32'd21);
        resume_req = 1; tick(); resume_req = 0;
        bp_wr_en = 1; bp_wr_idx = 2'd0; bp_wr_valid = 0;
        tick();
        clear_inputs();
        chk("ebreak_exec_instret", instret_cnt, 32'd22);
        chk("ebreak_exec_pc", pc, 32'h44);

        // halt_req in RUN at 0x10, then three single steps
        pc = 32'h10; halt_req = 1; tick(); halt_req = 0;
        chk("req_cause", {29'd0, halt_cause}, 32'd1);
        chk("req_pc", pc, 32'h14);
        base = m_ret;
        for (int s = 0; s < 3; s++) begin
            step_req = 1; tick(); step_req = 0;
            tick();
            chk("step_cause", {29'd0, halt_cause}, 32'd4);
        end
        chk("step_instret", instret_cnt, base + 32'd3);
        chk("step_pc", pc, 32'h20);

        // Held halt_req blocks resume; resume beats step
        halt_req = 1; resume_req = 1; tick();
        chk("req_blocks_resume", {31'd0, halted}, 32'd1);
        halt_req = 0; step_req = 1; tick(); clear_inputs();
        chk("resume_over_step", {31'd0, halted}, 32'd0);
        tick();

        // Randomized phase
        for (int n = 0; n < 400; n++) begin
            halt_req    = ($urandom_range(0, 9) == 0);
            resume_req  = ($urandom_range(0, 5) == 0);
            step_req    = ($urandom_range(0, 4) == 0);
            bp_wr_en    = ($urandom_range(0, 11) == 0);
            bp_wr_idx   = 2'($urandom_range(0, 3));
            bp_wr_addr  = 32'($urandom_range(0, 31)) << 2;
            bp_wr_valid = 1'($urandom_range(0, 1));
            tick();
        end
        clear_inputs();

        // Reach HALTED, arm a breakpoint at 0x8, enter STEP, then reset
        for (int n = 0; n < 3 && !m_halted; n++) begin
            halt_req = 1; tick();
        end
        halt_req = 0;
        bp_wr_en = 1; bp_wr_idx = 2'd2; bp_wr_addr = 32'h8; bp_wr_valid = 1;
        tick();
        clear_inputs();
        step_req = 1; tick(); step_req = 0;
        rst_n = 1'b0;
        #1;
        chk("midstep_halted", {31'd0, halted}, 32'd0);
        chk("midstep_cause", {29'd0, halt_cause}, 32'd0);
        chk("midstep_cycle", cycle_cnt, 32'd0);
        chk("midstep_instret", instret_cnt, 32'd0);
        m_reset();
        pc = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) tick();
        chk("bp_cleared_pc", pc, 32'h10);

        // Counter wrap on the 8-bit instance, which starts halted
        #1;
        chk("w_rst_halted", {31'd0, halted2}, 32'd1);
        rst2_n = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            @(posedge clk);
            #1;
            if (k == 255) chk("wrap_ff", {24'd0, cyc2}, 32'hFF);
        end
        chk("wrap_zero", {24'd0, cyc2}, 32'd0);
        chk("wrap_halted", {31'd0, halted2}, 32'd1);
        chk("wrap_instret", {24'd0, ret2}, 32'd0);
        chk("wrap_core_en", {31'd0, core_en2}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- Run-control sequencer for the single-cycle RV32I core.
- Gates the core's architectural updates (PC, register file and data-memory writes) through one enable.
- Provides external halt, resume and single-step control, address breakpoints, and EBREAK halting.
- Keeps cycle and retired-instruction counters; sits beside the datapath and watches the current PC and instruction.

Parameters:
- XLEN, 32, width of PC, instruction, breakpoint address and counters.
- NUM_BP, 2, number of address breakpoint slots (1..8).
- START_HALTED, 0, when 1 the core comes out of reset in HALTED; when 0 it comes out in RUN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- pc  in  XLEN  current PC from datapath.
- instr  in  32  instruction currently fetched at pc.
- halt_req  in  1  level request to stop.
- resume_req  in  1  pulse: leave HALTED and free-run.
- step_req  in  1  pulse: execute exactly one instruction, then halt.
- bp_wr_en  in  1  breakpoint slot write strobe.
- bp_wr_idx  in  $clog2(NUM_BP) (min 1)  slot index.
- bp_wr_addr  in  XLEN  breakpoint PC.
- bp_wr_valid  in  1  slot enable value written.
- core_en  out  1  enable for PC, regfile and dmem writes (combinational).
- halted  out  1  registered; 1 in HALTED state.
- halt_cause  out  3  registered; reason for the most recent halt.
- cycle_cnt  out  XLEN  clocks since reset.
- instret_cnt  out  XLEN  instructions retired (cycles with core_en=1).

Behaviour:
- Reset (rst=0, async):
  - state=HALTED if START_HALTED else RUN; halted=START_HALTED.
  - halt_cause=NONE(0); counters=0; all bp valid=0; mask=0.
- States:
  - RUN: core_en=1 unless a halt hit; halted=0.
  - HALTED: core_en=0; halted=1.
  - STEP: core_en=1 for exactly one cycle, unconditionally.
- Halt hit (combinational) = !mask && (any valid slot with addr==pc || instr==32'h00100073 EBREAK).
  - On a hit in RUN: core_en=0 that cycle, so the instruction is not executed.
  - Next state HALTED; cause = BP(2) if an address matches, else EBREAK(3). BP wins when both apply.
- halt_req in RUN with no hit:
  - The current instruction executes (core_en=1).
  - Next state HALTED, cause REQ(1).
  - If a hit occurs in the same cycle, the hit rule wins (instruction suppressed, cause BP or EBREAK).
- HALTED transitions:
  - resume_req → RUN, mask=1.
  - else step_req → STEP.
  - resume_req wins over step_req.
  - halt_req held high while HALTED blocks resume (stays HALTED); step is still allowed.
- STEP:
  - Executes the instruction at pc; breakpoints and EBREAK are ignored.
  - Next state HALTED, cause STEP(4).
- mask:
  - Set on the HALTED→RUN edge; cleared after the first RUN cycle.
  - Guarantees that resuming on a breakpoint or EBREAK executes that instruction once. EBREAK executes as a no-op in the datapath.
- Counters:
  - cycle_cnt increments every clock after reset, including while halted.
  - instret_cnt increments on each cycle with core_en=1.
  - Both wrap modulo 2^XLEN without a flag.
- Breakpoint writes:
  - Accepted in any state; slot index ≥ NUM_BP is ignored.
  - The write takes effect for the compare on the next cycle (same-cycle compare uses the old value).
- An async reset mid-step or mid-halt returns everything to the reset values immediately.

Decomposition:
- Shared package riscv_dbg_pkg:
  - run_state_e {RUN, HALTED, STEP}.
  - halt_cause_e {NONE=0, REQ=1, BP=2, EBREAK=3, STEP=4}.
  - localparam EBREAK_INSN = 32'h00100073.
- Sub-module bp_match:
  - NUM_BP registered slots with a write port, plus a combinational any-match output against pc.
  - Instantiated once.

Test Plan:
- Reset release with START_HALTED=0, halt_req=0 → halted=0, core_en=1; after 10 clocks cycle_cnt=10 and instret_cnt=10.
- Write slot0 addr=0x20 valid=1 while running; pc reaches 0x20 → core_en=0 that cycle, next cycle halted=1, halt_cause=2, instret_cnt unchanged; resume_req → instruction at 0x20 executes, pc advances to 0x24, no re-halt.
- instr=0x00100073 at pc=0x40 → halts, halt_cause=3, instret not incremented; resume → executed once, instret +1.
- While HALTED, pulse step_req three times → each pulse gives core_en=1 for one cycle, then halted=1 with halt_cause=4; instret_cnt +3 in total, pc advances by 12.
- halt_req asserted in RUN with pc=0x10, no breakpoint → core_en=1 that cycle, next cycle halted=1 with halt_cause=1; resume_req and step_req together while HALTED → RUN, not STEP.
- Assert rst=0 during STEP → immediately halted=START_HALTED, counters=0, breakpoints cleared; preload cycle_cnt near 0xFFFFFFFF and check it wraps to 0.
